// File: rtl/sram_ctrl.sv
// sram_ctrl: single-port controller for two asynchronous 32-bit SRAM banks
// (baseram / extram). A request is latched in IDLE, and the controller then
// runs a strobe sequence on the bank selected by addr[22], with WAIT_CYCLES
// extra cycles on the read and write strobes.
// Optional feature: define SRAM_BYTE_WRITE_EN to turn partial-byte writes
// into read-modify-write, and to complete be==0 writes without touching the RAM.
module sram_ctrl #(
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  be,
   output logic [31:0] rdata,
   output logic        ack,
   output logic        busy,
   output logic [19:0] baseram_addr,
   inout  wire  [31:0] baseram_data,
   output logic        baseram_ce,
   output logic        baseram_oe,
   output logic        baseram_we,
   output logic [19:0] extram_addr,
   inout  wire  [31:0] extram_data,
   output logic        extram_ce,
   output logic        extram_oe,
   output logic        extram_we
);

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 20;
   localparam int unsigned CW = 3;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD       = 3'd1,
      WR_SETUP = 3'd2,
      WR_PULSE = 3'd3,
      WR_HOLD  = 3'd4,
      DONE     = 3'd5
   } state_t;

   state_t          state_q, state_nxt;
   logic [CW-1:0]   cnt_q, cnt_nxt;
   logic            bank_q;
   logic            rmw_q;
   logic [DW-1:0]   wdata_q;
   logic            base_drv_q, ext_drv_q;

   logic            start_c, sel_bank_c, last_c;
   logic            rmw_start_c, skip_c;
   logic            ce_act_c, oe_act_c, we_act_c, drv_act_c;
   logic [DW-1:0]   rd_word_c;
   logic            unused_ok_c;

   assign start_c    = (state_q == IDLE) && req;
   assign sel_bank_c = (state_q == IDLE) ? addr[22] : bank_q;
   assign last_c     = (cnt_q == CW'(WAIT_CYCLES));
   assign rd_word_c  = bank_q ? extram_data : baseram_data;
   assign unused_ok_c = ^{addr[31:23], addr[1:0], be};

`ifdef SRAM_BYTE_WRITE_EN
   logic [3:0] be_q;

   // Overlay the enabled write bytes onto the word read back from the RAM
   function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] rd_w,
                                                 input logic [DW-1:0] wr_w,
                                                 input logic [3:0]    en);
      logic [DW-1:0] m;
      m = rd_w;
      for (int i = 0; i < 4; i++) begin
         if (en[i]) m[8*i +: 8] = wr_w[8*i +: 8];
      end
      return m;
   endfunction

   assign rmw_start_c = start_c && we && (be != 4'hF) && (be != 4'h0);
   assign skip_c      = start_c && we && (be == 4'h0);
`else
   assign rmw_start_c = 1'b0;
   assign skip_c      = 1'b0;
`endif

   // Next-state and wait counter
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      case (state_q)
         IDLE: begin
            cnt_nxt = '0;
            if (req) begin
               if (skip_c)                   state_nxt = DONE;
               else if (we && !rmw_start_c)  state_nxt = WR_SETUP;
               else                          state_nxt = RD;
            end
         end
         RD: begin
            if (last_c) begin
               cnt_nxt   = '0;
               state_nxt = rmw_q ? WR_SETUP : DONE;
            end else begin
               cnt_nxt = cnt_q + CW'(1);
            end
         end
         WR_SETUP: begin
            cnt_nxt   = '0;
            state_nxt = WR_PULSE;
         end
         WR_PULSE: begin
            if (last_c) begin
               cnt_nxt   = '0;
               state_nxt = WR_HOLD;
            end else begin
               cnt_nxt = cnt_q + CW'(1);
            end
         end
         WR_HOLD: state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Strobe activity implied by the state being entered
   assign ce_act_c  = (state_nxt == RD) || (state_nxt == WR_SETUP) ||
                      (state_nxt == WR_PULSE) || (state_nxt == WR_HOLD);
   assign oe_act_c  = (state_nxt == RD);
   assign we_act_c  = (state_nxt == WR_PULSE);
   assign drv_act_c = (state_nxt == WR_SETUP) || (state_nxt == WR_PULSE) ||
                      (state_nxt == WR_HOLD);

   // State, request latch, registered strobes and read capture
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         bank_q       <= 1'b0;
         rmw_q        <= 1'b0;
         wdata_q      <= '0;
         rdata        <= '0;
         ack          <= 1'b0;
         busy         <= 1'b0;
         baseram_addr <= '0;
         extram_addr  <= '0;
         baseram_ce   <= 1'b1;
         baseram_oe   <= 1'b1;
         baseram_we   <= 1'b1;
         extram_ce    <= 1'b1;
         extram_oe    <= 1'b1;
         extram_we    <= 1'b1;
         base_drv_q   <= 1'b0;
         ext_drv_q    <= 1'b0;
`ifdef SRAM_BYTE_WRITE_EN
         be_q         <= '0;
`endif
      end else begin
         state_q    <= state_nxt;
         cnt_q      <= cnt_nxt;
         ack        <= (state_nxt == DONE);
         busy       <= (state_nxt != IDLE);
         baseram_ce <= ~(ce_act_c  & ~sel_bank_c);
         baseram_oe <= ~(oe_act_c  & ~sel_bank_c);
         baseram_we <= ~(we_act_c  & ~sel_bank_c);
         base_drv_q <=  drv_act_c  & ~sel_bank_c;
         extram_ce  <= ~(ce_act_c  &  sel_bank_c);
         extram_oe  <= ~(oe_act_c  &  sel_bank_c);
         extram_we  <= ~(we_act_c  &  sel_bank_c);
         ext_drv_q  <=  drv_act_c  &  sel_bank_c;
         if (start_c) begin
            bank_q  <= addr[22];
            rmw_q   <= rmw_start_c;
            wdata_q <= wdata;
            if (addr[22]) extram_addr  <= AW'(addr[21:2]);
            else          baseram_addr <= AW'(addr[21:2]);
`ifdef SRAM_BYTE_WRITE_EN
            be_q    <= be;
`endif
         end
         if ((state_q == RD) && last_c) begin
`ifdef SRAM_BYTE_WRITE_EN
            if (rmw_q) wdata_q <= merge_bytes(rd_word_c, wdata_q, be_q);
            else       rdata   <= rd_word_c;
`else
            rdata <= rd_word_c;
`endif
         end
      end
   end

   // RAM data buses: driven only by the selected bank during the write phases
   assign baseram_data = base_drv_q ? wdata_q : {DW{1'bz}};
   assign extram_data  = ext_drv_q  ? wdata_q : {DW{1'bz}};

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed self-checking bench for sram_ctrl with
// behavioural models of both SRAM banks (weakly pulled-up data buses).
module tb_sram_ctrl;

   localparam int unsigned WAIT    = 1;
   localparam int          TIMEOUT = 40;

   logic        clk, rst, req, we;
   logic [31:0] addr, wdata;
   logic [3:0]  be;
   logic [31:0] rdata;
   logic        ack, busy;
   logic [19:0] baseram_addr, extram_addr;
   wire  [31:0] baseram_data, extram_data;
   logic        baseram_ce, baseram_oe, baseram_we;
   logic        extram_ce, extram_oe, extram_we;

   logic [31:0] base_mem [256];
   logic [31:0] ext_mem  [256];

   int n_checks = 0;
   int n_errors = 0;
   int viol     = 0;
   bit mon_en   = 0;

   sram_ctrl #(.WAIT_CYCLES(WAIT)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
      .rdata(rdata), .ack(ack), .busy(busy),
      .baseram_addr(baseram_addr), .baseram_data(baseram_data),
      .baseram_ce(baseram_ce), .baseram_oe(baseram_oe), .baseram_we(baseram_we),
      .extram_addr(extram_addr), .extram_data(extram_data),
      .extram_ce(extram_ce), .extram_oe(extram_oe), .extram_we(extram_we)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Undriven bus bits read back as 1
   for (genvar i = 0; i < 32; i++) begin : g_pu
      pullup (baseram_data[i]);
      pullup (extram_data[i]);
   end

   // SRAM models: drive on read, capture on the rising edge of we
   assign baseram_data = (!baseram_ce && !baseram_oe && baseram_we) ? base_mem[baseram_addr[7:0]] : 32'bz;
   assign extram_data  = (!extram_ce  && !extram_oe  && extram_we)  ? ext_mem[extram_addr[7:0]]   : 32'bz;

   always @(posedge baseram_we) if (baseram_ce === 1'b0) base_mem[baseram_addr[7:0]] = baseram_data;
   always @(posedge extram_we)  if (extram_ce  === 1'b0) ext_mem[extram_addr[7:0]]   = extram_data;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Bus protocol monitor: oe/we exclusive, no contention while reading, idle bus released
   always @(negedge clk) begin
      if (mon_en) begin
         if (!baseram_oe && !baseram_we) viol++;
         if (!extram_oe  && !extram_we)  viol++;
         if (!baseram_oe && (baseram_data !== base_mem[baseram_addr[7:0]])) viol++;
         if (!extram_oe  && (extram_data  !== ext_mem[extram_addr[7:0]]))   viol++;
         if (baseram_ce && (baseram_data !== 32'hFFFF_FFFF)) viol++;
         if (extram_ce  && (extram_data  !== 32'hFFFF_FFFF)) viol++;
      end
   end

   // One access; counts negedges from the sampling edge to ack and strobe-low cycles
   task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                         output int lat, output int ce_n, output int oe_n, output int we_n, output int other_bad);
      logic sel;
      sel = a[22];
      lat = 0; ce_n = 0; oe_n = 0; we_n = 0; other_bad = 0;
      @(negedge clk);
      req = 1'b1; we = w; addr = a; wdata = d; be = b;
      @(posedge clk);
      #1 req = 1'b0;
      for (int i = 1; i <= TIMEOUT; i++) begin
         @(negedge clk);
         if (sel) begin
            if (!extram_ce) ce_n++;
            if (!extram_oe) oe_n++;
            if (!extram_we) we_n++;
            if (!(baseram_ce && baseram_oe && baseram_we)) other_bad++;
         end else begin
            if (!baseram_ce) ce_n++;
            if (!baseram_oe) oe_n++;
            if (!baseram_we) we_n++;
            if (!(extram_ce && extram_oe && extram_we)) other_bad++;
         end
         if (ack) begin
            lat = i;
            break;
         end
      end
   endtask

   initial begin
      int lat, ce_n, oe_n, we_n, ob;
      int acks, idle_ok, busy_lo, ack_seen;
      bit after_ack;

      for (int i = 0; i < 256; i++) begin
         base_mem[i] = 32'h0100_0000 + 32'(i);
         ext_mem[i]  = 32'h0200_0000 + 32'(i);
      end
      rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = 4'h0;
      repeat (3) @(negedge clk);
      mon_en = 1'b1;

      // Reset state
      check("rst_busy",    32'(busy), 32'd0);
      check("rst_ack",     32'(ack), 32'd0);
      check("rst_rdata",   rdata, 32'h0);
      check("rst_base_str", 32'({baseram_ce, baseram_oe, baseram_we}), 32'h7);
      check("rst_ext_str",  32'({extram_ce, extram_oe, extram_we}), 32'h7);
      check("rst_base_addr", 32'(baseram_addr), 32'h0);
      check("rst_base_bus",  baseram_data, 32'hFFFF_FFFF);
      @(negedge clk);
      rst = 1'b1;

      // Read baseram word 4
      base_mem[4] = 32'hDEAD_BEEF;
      access(1'b0, 32'h0000_0010, 32'h0, 4'hF, lat, ce_n, oe_n, we_n, ob);
      check("rd_lat",   32'(lat), 32'd3);
      check("rd_ce",    32'(ce_n), 32'd2);
      check("rd_oe",    32'(oe_n), 32'd2);
      check("rd_we",    32'(we_n), 32'd0);
      check("rd_other", 32'(ob), 32'd0);
      check("rd_addr",  32'(baseram_addr), 32'd4);
      check("rd_data",  rdata, 32'hDEAD_BEEF);

      // Full write to extram word 8
      access(1'b1, 32'h0040_0020, 32'h1234_5678, 4'hF, lat, ce_n, oe_n, we_n, ob);
      check("wr_lat",   32'(lat), 32'd5);
      check("wr_ce",    32'(ce_n), 32'd4);
      check("wr_oe",    32'(oe_n), 32'd0);
      check("wr_we",    32'(we_n), 32'd2);
      check("wr_other", 32'(ob), 32'd0);
      check("wr_addr",  32'(extram_addr), 32'd8);
      check("wr_mem",   ext_mem[8], 32'h1234_5678);
      check("wr_rdata_kept", rdata, 32'hDEAD_BEEF);

      // Read back with addr[31:23] and addr[1:0] set (must be ignored)
      access(1'b0, 32'hFF40_0023, 32'h0, 4'hF, lat, ce_n, oe_n, we_n, ob);
      check("rb_lat",  32'(lat), 32'd3);
      check("rb_addr", 32'(extram_addr), 32'd8);
      check("rb_data", rdata, 32'h1234_5678);
      check("rb_other", 32'(ob), 32'd0);

      // Partial byte-enable write to baseram word 0
      base_mem[0] = 32'hAABB_CCDD;
      access(1'b1, 32'h0000_0000, 32'h1122_3344, 4'b0101, lat, ce_n, oe_n, we_n, ob);
`ifdef SRAM_BYTE_WRITE_EN
      check("rmw_lat", 32'(lat), 32'd7);
      check("rmw_ce",  32'(ce_n), 32'd6);
      check("rmw_oe",  32'(oe_n), 32'd2);
      check("rmw_we",  32'(we_n), 32'd2);
      check("rmw_mem", base_mem[0], 32'hAA22_CC44);
      check("rmw_rdata_kept", rdata, 32'h1234_5678);
      base_mem[2] = 32'hCAFE_F00D;
      access(1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 4'h0, lat, ce_n, oe_n, we_n, ob);
      check("be0_lat", 32'(lat), 32'd1);
      check("be0_ce",  32'(ce_n), 32'd0);
      check("be0_mem", base_mem[2], 32'hCAFE_F00D);
`else
      check("bw_lat", 32'(lat), 32'd5);
      check("bw_oe",  32'(oe_n), 32'd0);
      check("bw_mem", base_mem[0], 32'h1122_3344);
      check("bw_rdata_kept", rdata, 32'h1234_5678);
`endif

      // Back-to-back reads with req held high
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 32'h0000_0004; be = 4'hF;
      acks = 0; idle_ok = 0; busy_lo = 0; after_ack = 1'b0;
      for (int i = 0; i < TIMEOUT; i++) begin
         @(negedge clk);
         if (!busy) busy_lo++;
         if (after_ack) begin
            if (!busy) idle_ok++;
            after_ack = 1'b0;
            if (acks == 3) begin
               req = 1'b0;
               break;
            end
         end
         if (ack) begin
            acks++;
            after_ack = 1'b1;
         end
      end
      req = 1'b0;
      check("b2b_acks",    32'(acks), 32'd3);
      check("b2b_idle",    32'(idle_ok), 32'd3);
      check("b2b_busy_lo", 32'(busy_lo), 32'd3);
      check("b2b_data",    rdata, 32'h0100_0001);

      // Reset asserted in the middle of the write pulse
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 32'h0000_0040; wdata = 32'h55AA_55AA; be = 4'hF;
      @(posedge clk);
      #1 req = 1'b0;
      @(posedge clk);
      #2;
      check("mid_in_pulse", 32'(baseram_we), 32'd0);
      rst = 1'b0;
      #1;
      check("mid_strobes", 32'({baseram_ce, baseram_oe, baseram_we}), 32'h7);
      check("mid_bus",     baseram_data, 32'hFFFF_FFFF);
      check("mid_busy",    32'(busy), 32'd0);
      ack_seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (ack) ack_seen++;
      end
      check("mid_no_ack", 32'(ack_seen), 32'd0);
      check("mid_rdata",  rdata, 32'h0);
      rst = 1'b1;
      access(1'b0, 32'h0000_0010, 32'h0, 4'hF, lat, ce_n, oe_n, we_n, ob);
      check("post_rst_lat",  32'(lat), 32'd3);
      check("post_rst_data", rdata, 32'hDEAD_BEEF);

      repeat (2) @(negedge clk);
      check("bus_monitor", 32'(viol), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
